// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: activation mode encoding and frame sizing.
// Used by relu_stream (optional RELU_STREAM_STATS_EN) and relu_lane.
package cnn_pkg;

    localparam logic [1:0] RELU_MODE_RELU   = 2'd0;
    localparam logic [1:0] RELU_MODE_LEAKY  = 2'd1;
    localparam logic [1:0] RELU_MODE_CAP    = 2'd2;
    localparam logic [1:0] RELU_MODE_BYPASS = 2'd3;

    localparam int LEAKY_SHIFT = 3;

    function automatic int beats_per_frame(
        input int map_size,
        input int num_lanes
    );
        return (map_size * map_size) / num_lanes;
    endfunction

endpackage

// File: rtl/relu_lane.sv
// One lane of the activation datapath: activation + rounding shift ahead of
// the S1 register, saturation/clip between S1 and the output register.
module relu_lane
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 5
) (
    input  logic [IN_WIDTH-1:0]  x,
    input  logic [1:0]           mode,
    input  logic [SHIFT_W-1:0]   shift,
    output logic [IN_WIDTH:0]    r,
    input  logic [IN_WIDTH:0]    r_s1,
    input  logic [1:0]           mode_s1,
    input  logic [OUT_WIDTH-1:0] cap_s1,
    output logic [OUT_WIDTH-1:0] y
);

    localparam int RW = IN_WIDTH + 1;
    localparam logic signed [RW-1:0] MAX_P =
        RW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_N =
        RW'(-(1 << (OUT_WIDTH - 1)));

    logic signed [RW-1:0] xs;
    logic signed [RW-1:0] a;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] rs;
    logic signed [RW-1:0] capx;
    logic signed [RW-1:0] hi;
    logic signed [RW-1:0] lo;
    logic                 over;
    logic                 under;

    always_comb begin
        xs  = {x[IN_WIDTH-1], x};
        a   = xs;
        rnd = '0;
        unique case (mode)
            RELU_MODE_RELU,
            RELU_MODE_CAP:    a = xs[RW-1] ? '0 : xs;
            RELU_MODE_LEAKY:  a = xs[RW-1] ? (xs >>> LEAKY_SHIFT) : xs;
            RELU_MODE_BYPASS: a = xs;
        endcase
        if (shift != '0) begin
            rnd = RW'(1) << (shift - 1'b1);
        end
        sum = a + rnd;
        // Shifts wider than the input always round to zero
        if (shift == '0) begin
            r = a;
        end else if (int'(shift) > IN_WIDTH) begin
            r = '0;
        end else begin
            r = sum >>> shift;
        end
    end

    always_comb begin
        rs   = r_s1;
        capx = RW'(cap_s1);
        hi   = MAX_P;
        lo   = MIN_N;
        unique case (mode_s1)
            RELU_MODE_RELU: lo = '0;
            RELU_MODE_CAP: begin
                lo = '0;
                hi = (capx > MAX_P) ? MAX_P : capx;
            end
            RELU_MODE_LEAKY,
            RELU_MODE_BYPASS: lo = MIN_N;
        endcase
        over  = rs > hi;
        under = rs < lo;
        if (over) begin
            y = hi[OUT_WIDTH-1:0];
        end else if (under) begin
            y = lo[OUT_WIDTH-1:0];
        end else begin
            y = rs[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/relu_stream.sv
// Lane-parallel streaming ReLU/requant stage with frame tracking.
// Optional per-frame statistics behind RELU_STREAM_STATS_EN.
module relu_stream
    import cnn_pkg::*;
#(
    parameter int IN_WIDTH  = 26,
    parameter int OUT_WIDTH = 8,
    parameter int NUM_LANES = 16,
    parameter int MAP_SIZE  = 16,
    parameter int SHIFT_W   = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     cfg_mode,
    input  logic [SHIFT_W-1:0]             cfg_shift,
    input  logic [OUT_WIDTH-1:0]           cfg_cap,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*IN_WIDTH-1:0]  in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0] out_data,
    output logic                           out_last,
    output logic                           frame_err
`ifdef RELU_STREAM_STATS_EN
    ,
    output logic [$clog2(MAP_SIZE*MAP_SIZE):0] stat_zero_cnt,
    output logic [$clog2(MAP_SIZE*MAP_SIZE):0] stat_sat_cnt,
    output logic                               stat_valid
`endif
);

    localparam int BEATS = beats_per_frame(MAP_SIZE, NUM_LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RW    = IN_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic                 advance;
    logic                 accept;
    logic                 first;
    logic                 at_end;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           mode_q;
    logic [1:0]           mode_e;
    logic [SHIFT_W-1:0]   shift_q;
    logic [SHIFT_W-1:0]   shift_e;
    logic [OUT_WIDTH-1:0] cap_q;
    logic [OUT_WIDTH-1:0] cap_e;
    logic                 s1_valid;
    logic                 s1_last;
    logic [1:0]           s1_mode;
    logic [OUT_WIDTH-1:0] s1_cap;

    logic [NUM_LANES-1:0][RW-1:0]        r_d;
    logic [NUM_LANES-1:0][RW-1:0]        s1_r;
    logic [NUM_LANES-1:0][OUT_WIDTH-1:0] y_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign first    = (cnt == '0);
    assign at_end   = (cnt == LAST_CNT);

    // The opening beat of a frame uses live config; the rest use the latch
    assign mode_e  = first ? cfg_mode  : mode_q;
    assign shift_e = first ? cfg_shift : shift_q;
    assign cap_e   = first ? cfg_cap   : cap_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        relu_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT_W   (SHIFT_W)
        ) u_lane (
            .x       (in_data[k*IN_WIDTH +: IN_WIDTH]),
            .mode    (mode_e),
            .shift   (shift_e),
            .r       (r_d[k]),
            .r_s1    (s1_r[k]),
            .mode_s1 (s1_mode),
            .cap_s1  (s1_cap),
            .y       (y_d[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            frame_err <= 1'b0;
            mode_q    <= '0;
            shift_q   <= '0;
            cap_q     <= '0;
        end else if (accept) begin
            if (first) begin
                mode_q  <= cfg_mode;
                shift_q <= cfg_shift;
                cap_q   <= cfg_cap;
            end
            if (in_last != at_end) begin
                frame_err <= 1'b1;
            end
            cnt <= (in_last || at_end) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mode   <= '0;
            s1_cap    <= '0;
            s1_r      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_r    <= r_d;
                s1_mode <= mode_e;
                s1_cap  <= cap_e;
                s1_last <= in_last;
            end
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                out_data <= y_d;
            end
        end
    end

`ifdef RELU_STREAM_STATS_EN
    localparam int SW = $clog2(MAP_SIZE*MAP_SIZE) + 1;

    logic [NUM_LANES-1:0] neg_d;
    logic [NUM_LANES-1:0] s1_neg;
    logic [SW-1:0]        acc_zero;
    logic [SW-1:0]        acc_sat;
    logic [SW-1:0]        zero_sum;
    logic [SW-1:0]        sat_sum;
    logic                 rectify;

    assign rectify = (mode_e == RELU_MODE_RELU) ||
                     (mode_e == RELU_MODE_CAP);

    // A lane clipped exactly when its saturated value differs from r
    always_comb begin
        neg_d    = '0;
        zero_sum = acc_zero;
        sat_sum  = acc_sat;
        for (int k = 0; k < NUM_LANES; k++) begin
            neg_d[k] = rectify && in_data[(k+1)*IN_WIDTH-1];
            zero_sum = zero_sum + SW'(s1_neg[k]);
            sat_sum  = sat_sum + SW'(
                {{(RW-OUT_WIDTH){y_d[k][OUT_WIDTH-1]}}, y_d[k]}
                != s1_r[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_neg        <= '0;
            acc_zero      <= '0;
            acc_sat       <= '0;
            stat_zero_cnt <= '0;
            stat_sat_cnt  <= '0;
            stat_valid    <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (advance && in_valid) begin
                s1_neg <= neg_d;
            end
            if (advance && s1_valid) begin
                if (s1_last) begin
                    stat_zero_cnt <= zero_sum;
                    stat_sat_cnt  <= sat_sum;
                    stat_valid    <= 1'b1;
                    acc_zero      <= '0;
                    acc_sat       <= '0;
                end else begin
                    acc_zero <= zero_sum;
                    acc_sat  <= sat_sum;
                end
            end
        end
    end
`endif

endmodule
